// File: rtl/fifo_burst_rd.sv
// Burst reader: pulls a requested number of words from a FIFO and streams them out
// through a 2-entry skid buffer. Optional empty-stall timeout under BURST_RD_TMO_EN.
module fifo_burst_rd #(
    parameter int FIFO_DWTH = 4,
    parameter int LEN_W     = 6,
    parameter int TMO_CYC   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    input  logic                 empty,
    input  logic [FIFO_DWTH-1:0] dout,
    input  logic                 valid,
    output logic                 rden,
    output logic [FIFO_DWTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tmo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] issued_reg, issued_next;
    logic [LEN_W-1:0] delivered_reg, delivered_next;
    logic [1:0]       inflight_reg, inflight_next;
    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, wr_ptr_next;
    logic             rd_ptr_reg, rd_ptr_next;

    logic [FIFO_DWTH-1:0] skid_data [2];

    logic       xfer;
    logic       accept;
    logic       tmo_hit;
    logic [2:0] pending;

    assign xfer   = m_valid & m_ready;
    assign accept = valid & (inflight_reg != 2'd0);

    // Words that will still occupy the skid once this cycle's pop retires; counting
    // the pop keeps a back-to-back stream at one word per cycle.
    assign pending = 3'(count_reg) + 3'(inflight_reg) - 3'(xfer);

    assign rden = (state_reg == READ) && !empty && (issued_reg < len_reg) &&
                  (pending < 3'd2) && !tmo_hit;

    assign m_valid = (count_reg != 2'd0);
    assign m_data  = m_valid ? skid_data[rd_ptr_reg] : '0;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign tmo     = tmo_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_skid
            logic [FIFO_DWTH-1:0] entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (accept && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= dout;
                end
            end

            assign skid_data[gi] = entry_reg;
        end
    endgenerate

`ifdef BURST_RD_TMO_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] stall_reg, stall_next;

    assign tmo_hit = (state_reg == READ) && (stall_reg == TMO_W'(TMO_CYC));

    // Only an unbroken run of empty cycles with reads still owed counts toward abort.
    always_comb begin
        stall_next = '0;
        if ((state_reg == READ) && !rden && !tmo_hit && empty && (issued_reg < len_reg)) begin
            stall_next = stall_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_next;
        end
    end
`else
    // TMO_CYC has no role in this build; the comparison is constant false.
    assign tmo_hit = (TMO_CYC < 0);
`endif

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        issued_next    = issued_reg;
        delivered_next = delivered_reg;
        inflight_next  = inflight_reg + 2'(rden) - 2'(accept);
        count_next     = count_reg + 2'(accept) - 2'(xfer);
        wr_ptr_next    = accept ? ~wr_ptr_reg : wr_ptr_reg;
        rd_ptr_next    = xfer ? ~rd_ptr_reg : rd_ptr_reg;

        if (rden) begin
            issued_next = issued_reg + 1'b1;
        end
        if (xfer) begin
            delivered_next = delivered_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next       = burst_len;
                    issued_next    = '0;
                    delivered_next = '0;
                    inflight_next  = '0;
                    state_next     = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (tmo_hit) begin
                    state_next    = IDLE;
                    inflight_next = '0;
                    count_next    = '0;
                    wr_ptr_next   = 1'b0;
                    rd_ptr_next   = 1'b0;
                end else if (issued_reg == len_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((delivered_reg == len_reg) && (count_reg == 2'd0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            issued_reg    <= '0;
            delivered_reg <= '0;
            inflight_reg  <= '0;
            count_reg     <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            issued_reg    <= issued_next;
            delivered_reg <= delivered_next;
            inflight_reg  <= inflight_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
        end
    end

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Directed bench for fifo_burst_rd with a behavioural FIFO (valid one cycle after rden).
// Timeout scenario is compiled in when BURST_RD_TMO_EN is defined.
module tb_fifo_burst_rd;

    localparam int DW = 4;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          empty = 1'b1;
    logic [DW-1:0] dout = '0;
    logic          valid = 1'b0;
    logic          rden;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          tmo;

    always #5 clk = ~clk;

    fifo_burst_rd #(.FIFO_DWTH(DW), .LEN_W(LW), .TMO_CYC(64)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .empty(empty), .dout(dout), .valid(valid), .rden(rden),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .tmo(tmo)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] rx[$];
    int cyc = 0;
    int ready_mode = 0;
    bit nxt_valid;
    logic [DW-1:0] nxt_dout;

    int n_rden, n_done, n_tmo, first_rden, last_rden, first_xfer, last_xfer;
    int done_cyc, busy_fall, rden_empty, rden_full, occ, occ_max, infl;
    int stab_viol, empty_run, tmo_run, start_cyc;
    bit prev_hold;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_rden = 0; n_done = 0; n_tmo = 0;
        first_rden = -1; last_rden = -1; first_xfer = -1; last_xfer = -1;
        done_cyc = -1; busy_fall = -1; rden_empty = 0; rden_full = 0;
        occ = 0; occ_max = 0; infl = 0; stab_viol = 0;
        empty_run = 0; tmo_run = -1; prev_hold = 0; prev_data = '0;
        rx.delete();
    endtask

    // One clock: sample at negedge, drive FIFO response and m_ready after the posedge.
    task automatic cycle();
        bit xfer, wr;
        @(negedge clk);
        xfer = m_valid && m_ready;
        wr   = valid && (infl > 0);
        if (prev_hold && (!m_valid || m_data !== prev_data)) stab_viol++;
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        if (rden) begin
            n_rden++;
            if (first_rden < 0) first_rden = cyc;
            last_rden = cyc;
            if (empty) rden_empty++;
            if ((occ - int'(xfer)) >= 2) rden_full++;
        end
        if (xfer) begin
            rx.push_back(m_data);
            $display("xfer cyc=%0d data=%0d", cyc, m_data);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (!busy && done_cyc >= 0 && busy_fall < 0 && cyc > done_cyc) busy_fall = cyc;
        if (rden) empty_run = 0;
        else if (busy && empty && !tmo) empty_run++;
        if (tmo) begin
            n_tmo++;
            tmo_run = empty_run;
        end
        occ = occ + int'(wr) - int'(xfer);
        if (occ > occ_max) occ_max = occ;
        infl = infl + int'(rden) - int'(wr);
        if (rden && q.size() > 0) begin
            nxt_valid = 1'b1;
            nxt_dout  = q.pop_front();
        end else begin
            nxt_valid = 1'b0;
            nxt_dout  = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
        valid = nxt_valid;
        dout  = nxt_dout;
        empty = (q.size() == 0);
        m_ready = (ready_mode == 1) ? ~m_ready : 1'b1;
    endtask

    task automatic start_burst(input int len);
        burst_len = LW'(len);
        start = 1'b1;
        start_cyc = cyc;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (busy_fall < 0 && k < budget) begin
            cycle();
            k++;
        end
        check({tag, "_finished"}, 32'(busy_fall >= 0), 1);
    endtask

    task automatic load(input int first, input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(DW'(first + i));
        empty = (q.size() == 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_rden", rden, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tmo", tmo, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Burst of 8 at full rate; a stray start mid-burst must be ignored.
        clear_stats(); ready_mode = 0; load(1, 8);
        start_burst(8);
        repeat (3) cycle();
        burst_len = LW'(3); start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done("b8", 40);
        check("b8_count", rx.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("b8_word%0d", i), (i < rx.size()) ? rx[i] : 'x, i + 1);
        check("b8_xfer_span", last_xfer - first_xfer, 7);
        check("b8_rden_cycles", n_rden, 8);
        check("b8_rden_span", last_rden - first_rden, 7);
        check("b8_done_pulses", n_done, 1);
        check("b8_busy_fall", busy_fall - done_cyc, 1);
        check("b8_tmo", n_tmo, 0);

        // Burst of 5 with m_ready toggling; FIFO holds 7 so exactly 5 reads must occur.
        clear_stats(); ready_mode = 1; load(9, 7);
        start_burst(5);
        wait_done("b5", 60);
        ready_mode = 0;
        check("b5_count", rx.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("b5_word%0d", i), (i < rx.size()) ? rx[i] : 'x, i + 9);
        check("b5_occ_le2", 32'(occ_max <= 2), 1);
        check("b5_rden_while_full", rden_full, 0);
        check("b5_hold_stable", stab_viol, 0);
        check("b5_rden_cycles", n_rden, 5);
        check("b5_fifo_left", q.size(), 2);
        check("b5_done_pulses", n_done, 1);
        load(0, 0);

        // Burst of 6 where the FIFO runs dry after 3 words for a while.
        clear_stats(); load(1, 3);
        start_burst(6);
        repeat (8) cycle();
        repeat (10) cycle();
        check("stall_rden_so_far", n_rden, 3);
        check("stall_busy", busy, 1);
        for (int i = 4; i <= 6; i++) q.push_back(DW'(i));
        empty = 1'b0;
        wait_done("stall", 40);
        check("stall_count", rx.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("stall_word%0d", i), (i < rx.size()) ? rx[i] : 'x, i + 1);
        check("stall_rden_while_empty", rden_empty, 0);
        check("stall_done_pulses", n_done, 1);

        // Zero-length burst.
        clear_stats(); load(5, 2);
        start_burst(0);
        wait_done("zero", 10);
        check("zero_done_latency", done_cyc - start_cyc, 1);
        check("zero_rden", n_rden, 0);
        check("zero_done_pulses", n_done, 1);
        load(0, 0);

        // Reset mid-burst after 3 delivered words, then spurious valid, then a fresh burst.
        clear_stats(); load(1, 8);
        start_burst(8);
        for (int k = 0; k < 30 && rx.size() < 3; k++) cycle();
        check("mid_reached3", rx.size(), 3);
        rst = 1'b1;
        valid = 1'b0;
        #1;
        check("mid_rst_rden", rden, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_tmo", tmo, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_stats(); load(0, 0);
        valid = 1'b1; dout = DW'(7);
        cycle();
        check("spurious_valid_ignored", m_valid, 0);
        clear_stats(); load(10, 4);
        start_burst(4);
        wait_done("post_rst", 30);
        check("post_rst_count", rx.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("post_rst_word%0d", i), (i < rx.size()) ? rx[i] : 'x, i + 10);
        check("post_rst_done_pulses", n_done, 1);

`ifdef BURST_RD_TMO_EN
        // FIFO supplies only 2 of 6 words; the burst must abort after 64 empty cycles.
        clear_stats(); load(1, 2);
        start_burst(6);
        for (int k = 0; k < 120 && n_tmo == 0; k++) cycle();
        check("tmo_seen", n_tmo, 1);
        check("tmo_empty_cycles", tmo_run, 64);
        check("tmo_busy_after", busy, 0);
        check("tmo_m_valid_after", m_valid, 0);
        repeat (4) cycle();
        check("tmo_done", n_done, 0);
        check("tmo_pulses", n_tmo, 1);
        check("tmo_words", rx.size(), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fifo_burst_rd.md
FIFO_BURST_RD -- requirements
Module: fifo_burst_rd

Interface
REQ-001 SHALL have parameter FIFO_DWTH, default 4, meaning the FIFO word and stream data width.
REQ-002 SHALL have parameter LEN_W, default 6, meaning the width of the burst-length request.
REQ-003 SHALL have parameter TMO_CYC, default 64, meaning empty-stall cycles before abort (used only with BURST_RD_TMO_EN).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  meaning the reset, which is asynchronous and active-high.
REQ-006 SHALL have port start  in  1  meaning the burst request, sampled only in IDLE.
REQ-007 SHALL have port burst_len  in  LEN_W  meaning words to read, latched with start.
REQ-008 SHALL have port empty  in  1  meaning the FIFO empty flag.
REQ-009 SHALL have port dout  in  FIFO_DWTH  meaning FIFO read data.
REQ-010 SHALL have port valid  in  1  meaning dout is valid, asserted the cycle after an accepted rden.
REQ-011 SHALL have port rden  out  1  meaning the FIFO read enable.
REQ-012 SHALL have port m_data  out  FIFO_DWTH  meaning stream output data.
REQ-013 SHALL have port m_valid  out  1  meaning m_data is valid.
REQ-014 SHALL have port m_ready  in  1  meaning the downstream accepts; transfer = m_valid & m_ready.
REQ-015 SHALL have port busy  out  1  meaning the FSM is not in IDLE.
REQ-016 SHALL have port done  out  1  meaning a one-cycle burst-complete pulse.
REQ-017 SHALL have port tmo  out  1  meaning a one-cycle abort pulse (held 0 without BURST_RD_TMO_EN).

Function
REQ-018 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-019 SHALL, in IDLE with start=1 and burst_len!=0, latch burst_len, clear the counters and enter READ; with burst_len==0 it SHALL go to DONE directly.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL drive rden=1 in READ only when empty=0, issued<len, and (skid occupancy + reads in flight) < 2.
REQ-022 SHALL hold a 2-entry skid buffer, write dout into it when valid=1, and present its head on m_data/m_valid in order.
REQ-023 SHALL increment a LEN_W-bit issued count per rden and a delivered count per stream transfer.
REQ-024 SHALL go from READ to DRAIN in the cycle after issued reaches len.
REQ-025 SHALL go from DRAIN to DONE when delivered==len and the skid buffer is empty.
REQ-026 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-027 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-028 SHALL allow a simultaneous skid write and stream transfer in one cycle without loss; occupancy is then unchanged.
REQ-029 SHALL sustain one word per cycle when empty=0 and m_ready=1 continuously.
REQ-030 SHALL ignore valid=1 with no read in flight.

Reset
REQ-031 SHALL, on rst=1, immediately force IDLE, clear the counters and the skid buffer, and drive rden, m_valid, busy, done, tmo = 0 and m_data = 0.
REQ-032 SHALL abandon a burst on reset mid-burst; FIFO words already read are discarded.

Configuration
REQ-033 SHALL, with macro BURST_RD_TMO_EN defined, count consecutive READ cycles with empty=1 and issued<len.
REQ-034 SHALL, with BURST_RD_TMO_EN defined, reset that count on any rden.
REQ-035 SHALL, with BURST_RD_TMO_EN defined, on reaching TMO_CYC, pulse tmo for one cycle, flush the skid buffer, suppress done and return to IDLE.
REQ-036 SHALL, without BURST_RD_TMO_EN, synthesize no timeout logic, tie tmo to 0, and let READ wait indefinitely on empty.

Verification
REQ-037 SHALL cover: FIFO holds 8 words 1..8, start with burst_len=8, m_ready=1 -> m_data 1..8 on consecutive cycles, rden high 8 cycles, done pulses once, busy falls the next cycle.
REQ-038 SHALL cover: burst_len=5, m_ready toggling 1/0 each cycle -> 5 words in order with no loss or duplication, skid occupancy never above 2, rden paused while full.
REQ-039 SHALL cover: FIFO empty for 10 cycles mid-burst of 6 -> rden=0 while empty, resumes on fill, all 6 delivered, done pulses.
REQ-040 SHALL cover: start with burst_len=0 -> no rden, done pulses one cycle after start.
REQ-041 SHALL cover: rst=1 asserted after 3 of 8 words -> all outputs 0 at once, IDLE, and a new burst of 4 runs correctly after release.
REQ-042 SHALL cover: with BURST_RD_TMO_EN and TMO_CYC=64, FIFO drained after 2 of 6 words -> tmo pulses after 64 empty cycles, done stays 0, IDLE.
